// File: rtl/memory_access_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - load/store operation encodings used by the EX->MEM interface
//   - TRUE/FALSE single-bit constants
//   - MEM stage FSM state type (MEM_IDLE / MEM_WAIT)
//   - store byte-enable helper
package memory_access_pkg;

    localparam logic [2:0] NOTLOAD  = 3'd0;
    localparam logic [2:0] LB       = 3'd1;
    localparam logic [2:0] LH       = 3'd2;
    localparam logic [2:0] LW       = 3'd3;
    localparam logic [2:0] LBU      = 3'd4;
    localparam logic [2:0] LHU      = 3'd5;

    localparam logic [1:0] NOTSTORE = 2'd0;
    localparam logic [1:0] SB       = 2'd1;
    localparam logic [1:0] SH       = 2'd2;
    localparam logic [1:0] SW       = 2'd3;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // Byte enables for a store of the given size at the given byte lane.
    function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] ofs);
        logic [3:0] be;
        case (st)
            SB:      be = 4'b0001 << ofs;
            SH:      be = ofs[1] ? 4'b1100 : 4'b0011;
            SW:      be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// Load alignment / extension for the MEM stage (purely combinational).
// Ports:
//   rdata     in  32  word returned by data memory
//   offset    in   2  byte offset of the access within the word
//   info_load in   3  load type (LB/LH/LW/LBU/LHU)
//   ld_data   out 32  selected lane, sign- or zero-extended to 32 bits
module memory_access_load_align
    import memory_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  info_load,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection: byte by full offset, half by offset[1] only.
    always_comb begin
        byte_s = 8'h00;
        case (offset)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (offset[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extension according to load type.
    always_comb begin
        ld_data = 32'h0000_0000;
        case (info_load)
            LB:      ld_data = {{24{byte_s[7]}}, byte_s};
            LBU:     ld_data = {24'h00_0000, byte_s};
            LH:      ld_data = {{16{half_s[15]}}, half_s};
            LHU:     ld_data = {16'h0000, half_s};
            LW:      ld_data = rdata;
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: issues loads/stores on a req/ack data-memory port,
// shifts store data into byte lanes, extends load data, and registers the
// result for WB. Stalls upstream stages while an access is outstanding.
// Optional build macro: MEM_MISALIGN_TRAP_EN (adds misalign_trap output and
// suppresses misaligned half/word accesses).
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   alu_result, rs2E           EX result/address and store data
//   write_regE, info_loadE, info_storeE, dstreg_addrE  EX control
//   dmem_req/we/addr/be/wdata  memory request (combinational)
//   dmem_rdata, dmem_ack       memory response
//   stall_mem                  hold EX/ID/IF this cycle
//   forward_data_writemem      alu_result, forwarded upstream
//   wb_data, write_regM, dstreg_addrM  registered WB outputs
//   misalign_trap              registered one-cycle trap pulse (optional)
module memory_access
    import memory_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       rs2E,
    input  logic              write_regE,
    input  logic [2:0]        info_loadE,
    input  logic [1:0]        info_storeE,
    input  logic [4:0]        dstreg_addrE,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall_mem,
    output logic [31:0]       forward_data_writemem,
    output logic [31:0]       wb_data,
    output logic              write_regM,
    output logic [4:0]        dstreg_addrM
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign_trap
`endif
);

    mem_state_e  state_r;
    mem_state_e  next_state_s;
    logic        is_load_s;
    logic        is_store_s;
    logic        memop_s;
    logic        misalign_s;
    logic        req_s;
    logic        stall_s;
    logic        complete_s;
    logic [31:0] ld_data_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic        we_s;
    logic [31:0] wb_data_r;
    logic        write_reg_r;
    logic [4:0]  dstreg_r;

    // A simultaneous load+store encoding is treated as a load.
    assign is_load_s  = (info_loadE != NOTLOAD);
    assign is_store_s = (info_storeE != NOTSTORE);
    assign memop_s    = is_load_s | is_store_s;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_trap_r;

    // Detect halfword/word accesses that do not sit on their natural boundary.
    always_comb begin
        misalign_s = FALSE;
        if (is_load_s) begin
            case (info_loadE)
                LH, LHU: misalign_s = alu_result[0];
                LW:      misalign_s = |alu_result[1:0];
                default: misalign_s = FALSE;
            endcase
        end else begin
            case (info_storeE)
                SH:      misalign_s = alu_result[0];
                SW:      misalign_s = |alu_result[1:0];
                default: misalign_s = FALSE;
            endcase
        end
    end

    // Trap pulse: one cycle per misaligned access seen while idle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            misalign_trap_r <= 1'b0;
        end else begin
            misalign_trap_r <= (state_r == MEM_IDLE) && memop_s && misalign_s;
        end
    end

    assign misalign_trap = misalign_trap_r;
`else
    assign misalign_s = FALSE;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= MEM_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state, request and stall decode.
    always_comb begin
        next_state_s = state_r;
        req_s        = FALSE;
        stall_s      = FALSE;
        complete_s   = FALSE;
        case (state_r)
            MEM_IDLE: begin
                if (memop_s && !misalign_s) begin
                    req_s = TRUE;
                    if (dmem_ack) begin
                        complete_s = TRUE;
                    end else begin
                        stall_s      = TRUE;
                        next_state_s = MEM_WAIT;
                    end
                end else begin
                    next_state_s = MEM_IDLE;
                end
            end
            MEM_WAIT: begin
                req_s = TRUE;
                if (dmem_ack) begin
                    complete_s   = TRUE;
                    next_state_s = MEM_IDLE;
                end else begin
                    stall_s = TRUE;
                end
            end
            default: next_state_s = MEM_IDLE;
        endcase
    end

    // Store lane placement and byte enables; loads read the whole word.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
        we_s    = FALSE;
        if (is_load_s) begin
            be_s = 4'b1111;
        end else begin
            be_s = store_be(info_storeE, alu_result[1:0]);
            we_s = is_store_s;
            case (info_storeE)
                SB:      wdata_s = {4{rs2E[7:0]}};
                SH:      wdata_s = {2{rs2E[15:0]}};
                SW:      wdata_s = rs2E;
                default: wdata_s = 32'h0000_0000;
            endcase
        end
    end

    memory_access_load_align u_load_align (
        .rdata     (dmem_rdata),
        .offset    (alu_result[1:0]),
        .info_load (info_loadE),
        .ld_data   (ld_data_s)
    );

    // WB pipeline register: ALU pass-through, load completion, or bubble.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wb_data_r   <= 32'h0000_0000;
            write_reg_r <= 1'b0;
            dstreg_r    <= 5'd0;
        end else begin
            if ((state_r == MEM_IDLE) && !memop_s) begin
                wb_data_r   <= alu_result;
                write_reg_r <= write_regE;
                dstreg_r    <= dstreg_addrE;
            end else if (complete_s) begin
                if (is_load_s) begin
                    wb_data_r   <= ld_data_s;
                    write_reg_r <= write_regE;
                end else begin
                    write_reg_r <= 1'b0;
                end
                dstreg_r <= dstreg_addrE;
            end else begin
                // Stalled or trapped access: send a bubble to WB.
                write_reg_r <= 1'b0;
            end
        end
    end

    // The request is dropped immediately while reset is asserted.
    assign dmem_req              = req_s & rstn;
    assign stall_mem             = stall_s & rstn;
    assign dmem_we               = we_s;
    assign dmem_addr             = {alu_result[ADDR_W-1:2], 2'b00};
    assign dmem_be               = be_s;
    assign dmem_wdata            = wdata_s;
    assign forward_data_writemem = alu_result;
    assign wb_data               = wb_data_r;
    assign write_regM            = write_reg_r;
    assign dstreg_addrM          = dstreg_r;

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

    localparam logic [2:0] NOTLOAD  = 3'd0;
    localparam logic [2:0] LB       = 3'd1;
    localparam logic [2:0] LH       = 3'd2;
    localparam logic [2:0] LW       = 3'd3;
    localparam logic [2:0] LBU      = 3'd4;
    localparam logic [2:0] LHU      = 3'd5;
    localparam logic [1:0] NOTSTORE = 2'd0;
    localparam logic [1:0] SB       = 2'd1;
    localparam logic [1:0] SH       = 2'd2;
    localparam logic [1:0] SW       = 2'd3;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] alu_result;
    logic [31:0] rs2E;
    logic        write_regE;
    logic [2:0]  info_loadE;
    logic [1:0]  info_storeE;
    logic [4:0]  dstreg_addrE;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall_mem;
    logic [31:0] forward_data_writemem;
    logic [31:0] wb_data;
    logic        write_regM;
    logic [4:0]  dstreg_addrM;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    memory_access #(.ADDR_W(32)) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .alu_result            (alu_result),
        .rs2E                  (rs2E),
        .write_regE            (write_regE),
        .info_loadE            (info_loadE),
        .info_storeE           (info_storeE),
        .dstreg_addrE          (dstreg_addrE),
        .dmem_req              (dmem_req),
        .dmem_we               (dmem_we),
        .dmem_addr             (dmem_addr),
        .dmem_be               (dmem_be),
        .dmem_wdata            (dmem_wdata),
        .dmem_rdata            (dmem_rdata),
        .dmem_ack              (dmem_ack),
        .stall_mem             (stall_mem),
        .forward_data_writemem (forward_data_writemem),
        .wb_data               (wb_data),
        .write_regM            (write_regM),
        .dstreg_addrM          (dstreg_addrM)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_trap         (misalign_trap)
`endif
    );

    typedef struct {
        logic [2:0]  ld;
        logic [1:0]  st;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic        wr;
        logic [4:0]  dst;
        logic        exp_req;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        chk_wb;
        logic [31:0] exp_wb;
        logic        exp_wrm;
    } vec_t;

    vec_t vecs[16];
    int   n_vec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic wr, input logic [4:0] dst,
                         input logic [31:0] rdata, input logic ack);
        info_loadE   = ld;
        info_storeE  = st;
        alu_result   = alu;
        rs2E         = rs2;
        write_regE   = wr;
        dstreg_addrE = dst;
        dmem_rdata   = rdata;
        dmem_ack     = ack;
    endtask

    function automatic vec_t mk(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] alu,
                                input logic [31:0] rs2, input logic [31:0] rdata, input logic wr,
                                input logic [4:0] dst, input logic exp_req, input logic exp_we,
                                input logic [31:0] exp_addr, input logic [3:0] exp_be,
                                input logic [31:0] exp_wdata, input logic chk_wb,
                                input logic [31:0] exp_wb, input logic exp_wrm);
        vec_t v;
        v.ld = ld; v.st = st; v.alu = alu; v.rs2 = rs2; v.rdata = rdata; v.wr = wr; v.dst = dst;
        v.exp_req = exp_req; v.exp_we = exp_we; v.exp_addr = exp_addr; v.exp_be = exp_be;
        v.exp_wdata = exp_wdata; v.chk_wb = chk_wb; v.exp_wb = exp_wb; v.exp_wrm = exp_wrm;
        return v;
    endfunction

    // Drive a load/store with a stalled ack: stall for n_wait cycles, then ack.
    task automatic slow_load(input string name, input logic [2:0] ld, input logic [31:0] alu,
                             input logic [31:0] rdata, input int n_wait, input logic [31:0] exp_wb);
        drive(NOTLOAD, NOTSTORE, 32'h0000_0055, 32'h0, 1'b1, 5'd1, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk({name, " pre wrM"}, {31'd0, write_regM}, 32'd1);
        drive(ld, NOTSTORE, alu, 32'h0, 1'b1, 5'd9, 32'hDEAD_DEAD, 1'b0);
        for (int i = 0; i < n_wait; i++) begin
            @(negedge clk);
            chk({name, " stall"}, {31'd0, stall_mem}, 32'd1);
            chk({name, " req"}, {31'd0, dmem_req}, 32'd1);
            @(posedge clk); #1;
            chk({name, " bubble wrM"}, {31'd0, write_regM}, 32'd0);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        chk({name, " ack stall"}, {31'd0, stall_mem}, 32'd0);
        @(posedge clk); #1;
        chk({name, " wb"}, wb_data, exp_wb);
        chk({name, " wrM"}, {31'd0, write_regM}, 32'd1);
        chk({name, " dst"}, {27'd0, dstreg_addrM}, 32'd9);
        drive(NOTLOAD, NOTSTORE, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    initial begin
        // Table: single-cycle operations (ack in the same cycle for memory ops).
        n_vec = 0;
        vecs[n_vec++] = mk(NOTLOAD, NOTSTORE, 32'h0000_1234, 32'h0, 32'h0, 1'b1, 5'd5,
                           1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0000_1234, 1'b1);
        vecs[n_vec++] = mk(NOTLOAD, SB, 32'h0000_0103, 32'h0000_00AB, 32'h0, 1'b1, 5'd6,
                           1'b1, 1'b1, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 1'b0, 32'h0, 1'b0);
        vecs[n_vec++] = mk(NOTLOAD, SB, 32'h0000_0100, 32'h1234_5678, 32'h0, 1'b1, 5'd6,
                           1'b1, 1'b1, 32'h0000_0100, 4'b0001, 32'h7878_7878, 1'b0, 32'h0, 1'b0);
        vecs[n_vec++] = mk(NOTLOAD, SH, 32'h0000_0102, 32'hCAFE_BEEF, 32'h0, 1'b0, 5'd6,
                           1'b1, 1'b1, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0, 1'b0);
        vecs[n_vec++] = mk(NOTLOAD, SH, 32'h0000_0100, 32'hCAFE_BEEF, 32'h0, 1'b0, 5'd6,
                           1'b1, 1'b1, 32'h0000_0100, 4'b0011, 32'hBEEF_BEEF, 1'b0, 32'h0, 1'b0);
        vecs[n_vec++] = mk(NOTLOAD, SW, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0, 1'b1, 5'd6,
                           1'b1, 1'b1, 32'h0000_0200, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        vecs[n_vec++] = mk(LW, NOTSTORE, 32'h0000_0204, 32'h0, 32'h89AB_CDEF, 1'b1, 5'd7,
                           1'b1, 1'b0, 32'h0000_0204, 4'b1111, 32'h0, 1'b1, 32'h89AB_CDEF, 1'b1);
        vecs[n_vec++] = mk(LH, NOTSTORE, 32'h0000_0102, 32'h0, 32'h8001_0000, 1'b1, 5'd8,
                           1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0, 1'b1, 32'hFFFF_8001, 1'b1);
        vecs[n_vec++] = mk(LHU, NOTSTORE, 32'h0000_0102, 32'h0, 32'h8001_0000, 1'b1, 5'd8,
                           1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0, 1'b1, 32'h0000_8001, 1'b1);
        vecs[n_vec++] = mk(LH, NOTSTORE, 32'h0000_0100, 32'h0, 32'h1234_7FFF, 1'b1, 5'd8,
                           1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0, 1'b1, 32'h0000_7FFF, 1'b1);
        vecs[n_vec++] = mk(LB, NOTSTORE, 32'h0000_0103, 32'h0, 32'h7F00_0000, 1'b1, 5'd10,
                           1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0, 1'b1, 32'h0000_007F, 1'b1);
        vecs[n_vec++] = mk(LB, NOTSTORE, 32'h0000_0102, 32'h0, 32'h00FF_0000, 1'b1, 5'd11,
                           1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        vecs[n_vec++] = mk(LBU, NOTSTORE, 32'h0000_0100, 32'h0, 32'h0000_00F0, 1'b1, 5'd12,
                           1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0, 1'b1, 32'h0000_00F0, 1'b1);
        // Load and store together: load wins, no write strobe.
        vecs[n_vec++] = mk(LW, SW, 32'h0000_0300, 32'h5555_5555, 32'h1111_2222, 1'b1, 5'd13,
                           1'b1, 1'b0, 32'h0000_0300, 4'b1111, 32'h0, 1'b1, 32'h1111_2222, 1'b1);
        vecs[n_vec++] = mk(NOTLOAD, NOTSTORE, 32'h0000_ABCD, 32'h0, 32'h0, 1'b0, 5'd3,
                           1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0000_ABCD, 1'b0);
`ifndef MEM_MISALIGN_TRAP_EN
        // Misaligned word silently accesses the aligned word.
        vecs[n_vec++] = mk(LW, NOTSTORE, 32'h0000_0106, 32'h0, 32'h0BAD_F00D, 1'b1, 5'd14,
                           1'b1, 1'b0, 32'h0000_0104, 4'b1111, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b1);
`endif

        // Reset
        rstn = 1'b0;
        drive(NOTLOAD, NOTSTORE, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        chk("reset wb_data", wb_data, 32'h0);
        chk("reset wrM", {31'd0, write_regM}, 32'd0);
        chk("reset dst", {27'd0, dstreg_addrM}, 32'd0);
        chk("reset req", {31'd0, dmem_req}, 32'd0);
        rstn = 1'b1;

        // Table-driven single-cycle vectors
        for (int i = 0; i < n_vec; i++) begin
            drive(vecs[i].ld, vecs[i].st, vecs[i].alu, vecs[i].rs2, vecs[i].wr, vecs[i].dst,
                  vecs[i].rdata, vecs[i].exp_req);
            @(negedge clk);
            chk($sformatf("v%0d req", i), {31'd0, dmem_req}, {31'd0, vecs[i].exp_req});
            chk($sformatf("v%0d stall", i), {31'd0, stall_mem}, 32'd0);
            chk($sformatf("v%0d fwd", i), forward_data_writemem, vecs[i].alu);
            if (vecs[i].exp_req) begin
                chk($sformatf("v%0d we", i), {31'd0, dmem_we}, {31'd0, vecs[i].exp_we});
                chk($sformatf("v%0d addr", i), dmem_addr, vecs[i].exp_addr);
                chk($sformatf("v%0d be", i), {28'd0, dmem_be}, {28'd0, vecs[i].exp_be});
                if (vecs[i].exp_we) begin
                    chk($sformatf("v%0d wdata", i), dmem_wdata, vecs[i].exp_wdata);
                end
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d wrM", i), {31'd0, write_regM}, {31'd0, vecs[i].exp_wrm});
            if (vecs[i].chk_wb) begin
                chk($sformatf("v%0d wb", i), wb_data, vecs[i].exp_wb);
                chk($sformatf("v%0d dst", i), {27'd0, dstreg_addrM}, {27'd0, vecs[i].dst});
            end
        end

        // Multi-cycle loads with delayed ack
        slow_load("lb slow", LB, 32'h0000_0101, 32'h0000_8000, 3, 32'hFFFF_FF80);
        slow_load("lbu slow", LBU, 32'h0000_0101, 32'h0000_8000, 3, 32'h0000_0080);
        slow_load("lhu slow", LHU, 32'h0000_0102, 32'h8001_0000, 1, 32'h0000_8001);

        // Reset while waiting on memory
        drive(NOTLOAD, NOTSTORE, 32'h0000_0077, 32'h0, 1'b1, 5'd2, 32'h0, 1'b0);
        @(posedge clk); #1;
        drive(LW, NOTSTORE, 32'h0000_0400, 32'h0, 1'b1, 5'd4, 32'h0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wait stall", {31'd0, stall_mem}, 32'd1);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        drive(NOTLOAD, NOTSTORE, 32'h0000_0099, 32'h0, 1'b0, 5'd4, 32'h0, 1'b0);
        @(negedge clk);
        chk("rst-wait req", {31'd0, dmem_req}, 32'd0);
        chk("rst-wait stall", {31'd0, stall_mem}, 32'd0);
        chk("rst-wait wrM", {31'd0, write_regM}, 32'd0);
        chk("rst-wait wb", wb_data, 32'h0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("stray ack req", {31'd0, dmem_req}, 32'd0);
        chk("stray ack stall", {31'd0, stall_mem}, 32'd0);
        @(posedge clk); #1;
        chk("stray ack wrM", {31'd0, write_regM}, 32'd0);
        chk("stray ack wb", wb_data, 32'h0000_0099);
        // FSM is back in IDLE: a fresh load without ack must stall.
        drive(LW, NOTSTORE, 32'h0000_0400, 32'h0, 1'b1, 5'd4, 32'h0, 1'b0);
        @(negedge clk);
        chk("post-rst stall", {31'd0, stall_mem}, 32'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h4444_4444;
        @(posedge clk); #1;
        chk("post-rst wb", wb_data, 32'h4444_4444);
        drive(NOTLOAD, NOTSTORE, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned word: no request, one-cycle trap, bubble to WB.
        drive(NOTLOAD, NOTSTORE, 32'h0000_0011, 32'h0, 1'b1, 5'd1, 32'h0, 1'b0);
        @(posedge clk); #1;
        drive(LW, NOTSTORE, 32'h0000_0102, 32'h0, 1'b1, 5'd3, 32'h0, 1'b0);
        @(negedge clk);
        chk("trap req", {31'd0, dmem_req}, 32'd0);
        chk("trap stall", {31'd0, stall_mem}, 32'd0);
        @(posedge clk); #1;
        chk("trap pulse", {31'd0, misalign_trap}, 32'd1);
        chk("trap wrM", {31'd0, write_regM}, 32'd0);
        drive(NOTLOAD, NOTSTORE, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk("trap clear", {31'd0, misalign_trap}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
